// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: group width,
// stage-count derivation and the per-stage pipeline record.
package cla_pkg;

  localparam int CLA_GROUP     = 4;
  localparam int CLA_MAX_WIDTH = 64;

  function automatic int cla_ng(input int width, input int group);
    return width / group;
  endfunction

  // Operands are stored un-inverted; each stage applies the mode itself.
  typedef struct packed {
    logic                     valid;
    logic                     mode;
    logic                     carry;
    logic [CLA_MAX_WIDTH-1:0] a;
    logic [CLA_MAX_WIDTH-1:0] b;
    logic [CLA_MAX_WIDTH-1:0] sum;
  } cla_stage_t;

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice with group propagate/generate.
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c_in,
  output logic [GROUP-1:0] s,
  output logic             c_out,
  output logic             p_grp,
  output logic             g_grp
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;

  // Carry into bit j as a flat sum of products, no ripple through c[].
  function automatic logic lookahead(input logic [GROUP-1:0] pv,
                                     input logic [GROUP-1:0] gv,
                                     input logic ci, input int j);
    logic acc;
    logic prod;
    acc = 1'b0;
    for (int k = 0; k < j; k++) begin
      prod = gv[k];
      for (int m = k + 1; m < j; m++) prod = prod & pv[m];
      acc = acc | prod;
    end
    prod = ci;
    for (int m = 0; m < j; m++) prod = prod & pv[m];
    return acc | prod;
  endfunction

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = c_in;
    for (int j = 1; j <= GROUP; j++) c[j] = lookahead(p, g, c_in, j);
    s     = p ^ c[GROUP-1:0];
    c_out = c[GROUP];
    p_grp = &p;
    g_grp = lookahead(p, g, 1'b0, GROUP);
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined adder/subtractor: one lookahead group resolved per stage, with
// skewed operand/sum registers and a single global stall.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = cla_ng(WIDTH, GROUP);

  cla_stage_t       in_rec;
  cla_stage_t       stage_d [NG];
  cla_stage_t       stage_q [NG];
  logic             advance;
  logic [NG-1:0]    grp_c;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic             b_msb_eff;

  always_comb begin
    in_rec              = '0;
    in_rec.valid        = in_valid;
    in_rec.mode         = sub;
    in_rec.carry        = sub ? 1'b1 : cin;
    in_rec.a[WIDTH-1:0] = x;
    in_rec.b[WIDTH-1:0] = y;
  end

  for (genvar i = 0; i < NG; i++) begin : g_stage
    cla_stage_t       src;
    cla_stage_t       nxt;
    logic [GROUP-1:0] b_eff;
    logic [GROUP-1:0] s;

    if (i == 0) begin : g_first
      assign src = in_rec;
    end else begin : g_next
      assign src = stage_q[i-1];
    end

    assign b_eff = src.mode ? ~src.b[i*GROUP +: GROUP] : src.b[i*GROUP +: GROUP];

    cla_group #(.GROUP(GROUP)) u_grp (
      .a     (src.a[i*GROUP +: GROUP]),
      .b     (b_eff),
      .c_in  (src.carry),
      .s     (s),
      .c_out (grp_c[i]),
      .p_grp (grp_p[i]),
      .g_grp (grp_g[i])
    );

    always_comb begin
      nxt                        = src;
      nxt.sum[i*GROUP +: GROUP]  = s;
      nxt.carry                  = grp_c[i];
    end

    assign stage_d[i] = nxt;

    // Group P/G must agree with the slice's own carry-out.
    always_comb begin
      assert (grp_c[i] == (grp_g[i] | (grp_p[i] & src.carry)));
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < NG; i++) stage_q[i] <= '0;
    end else if (advance) begin
      for (int i = 0; i < NG; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign out_valid = stage_q[NG-1].valid;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign z         = stage_q[NG-1].sum[WIDTH-1:0];
  assign cout      = stage_q[NG-1].carry;
  assign b_msb_eff = stage_q[NG-1].mode ? ~stage_q[NG-1].b[WIDTH-1] : stage_q[NG-1].b[WIDTH-1];
  assign ovf       = (stage_q[NG-1].a[WIDTH-1] == b_msb_eff) &&
                     (z[WIDTH-1] != stage_q[NG-1].a[WIDTH-1]);

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed table, stall/reset sequences and a
// randomized run scored against an arithmetic reference model.
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        res;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] x, y, z;
  logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0]  x8, y8, z8;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .z(z), .cout(cout), .ovf(ovf)
  );

  cla_pipe_adder #(.WIDTH(8), .GROUP(4)) dut8 (
    .clk(clk), .res(res), .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .y(y8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .z(z8), .cout(cout8), .ovf(ovf8)
  );

  typedef struct {
    logic [15:0] z;
    logic        c;
    logic        o;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sb;
    logic [15:0] ez;
    logic        ec;
    logic        eo;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_pop = 0;
  exp_t q[$];
  logic        hold_pend = 1'b0;
  logic [15:0] hz;
  logic        hc, ho;
  vec_t        tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the mode-selected operand.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic sb);
    exp_t        e;
    logic [15:0] be;
    logic [16:0] s;
    be  = sb ? ~b : b;
    s   = {1'b0, a} + {1'b0, be} + {16'd0, (sb ? 1'b1 : ci)};
    e.z = s[15:0];
    e.c = s[16];
    e.o = (a[15] == be[15]) && (e.z[15] != a[15]);
    return e;
  endfunction

  // Scoreboard and hold monitor; handshakes seen here complete at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!res) begin
      q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_z", z, hz);
        check("hold_cout", cout, hc);
        check("hold_ovf", ovf, ho);
      end
      hold_pend = out_valid && !out_ready;
      hz = z; hc = cout; ho = ovf;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("stale_beat", out_valid, 0);
        else begin
          e = q.pop_front();
          n_pop++;
          check("sb_z", z, e.z);
          check("sb_cout", cout, e.c);
          check("sb_ovf", ovf, e.o);
        end
      end
      if (in_valid && in_ready) q.push_back(model(x, y, cin, sub));
    end
  end

  task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic sb, input logic [15:0] ez, input logic ec,
                          input logic eo, input string nm);
    int lat;
    @(posedge clk); #1;
    x = a; y = b; cin = ci; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_lat"}, lat, 4);
    check({nm, "_z"}, z, ez);
    check({nm, "_cout"}, cout, ec);
    check({nm, "_ovf"}, ovf, eo);
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ez,
                       input logic ec, input logic eo, input string nm);
    int lat;
    @(posedge clk); #1;
    x8 = a; y8 = b; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_lat"}, lat, 2);
    check({nm, "_z"}, z8, ez);
    check({nm, "_cout"}, cout8, ec);
    check({nm, "_ovf"}, ovf8, eo);
  endtask

  task automatic drive_beat();
    logic acc;
    int   guard;
    x = 16'($urandom); y = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    in_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!acc) check("accept_timeout", acc, 1);
  endtask

  task automatic drain(input string nm);
    int guard;
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while ((q.size() != 0 || out_valid) && guard < 60) begin
      @(posedge clk); #1;
      guard++;
    end
    check({nm, "_drained"}, q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pop0;
    res = 1'b0;
    in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; x8 = '0; y8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_z", z, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_valid8", out_valid8, 0);
    #10 res = 1'b1;

    for (int i = 0; i < 8; i++)
      send_one(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sb, tbl[i].ez, tbl[i].ec, tbl[i].eo,
               $sformatf("tbl%0d", i));
    drain("tbl");

    // Eight back-to-back beats with a three-cycle downstream stall mid-stream.
    pop0 = n_pop;
    fork
      begin
        for (int i = 0; i < 8; i++) drive_beat();
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("stall");
    check("stall_count", n_pop - pop0, 8);

    // Reset with beats in flight and one result already presented.
    @(posedge clk); #1;
    x = 16'($urandom); y = 16'($urandom); sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 x = 16'($urandom);
    @(posedge clk); #1 x = 16'($urandom);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #2;
    check("rstmid_pre_valid", out_valid, 1);
    res = 1'b0;
    #1;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_z", z, 0);
    check("rstmid_cout", cout, 0);
    check("rstmid_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #3 res = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("no_stale", out_valid, 0);
    end
    send_one(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, "post_rst");
    drain("post_rst");

    send8(8'hF0, 8'h10, 8'h00, 1'b1, 1'b0, "w8_carry");
    send8(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, "w8_ovf");

    // Randomized traffic with random backpressure.
    repeat (300) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      x = 16'($urandom); y = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
